// File: rtl/sensor_poller_pkg.sv
// -----------------------------------------------------------------------------
// sensor_poller_pkg
// Shared definitions for the accelerometer poller: FSM state encoding, SPI
// register addresses and the configuration bytes written during init.
// -----------------------------------------------------------------------------
package sensor_poller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT_REQ  = 3'd1,
    ST_INIT_WAIT = 3'd2,
    ST_PERIOD    = 3'd3,
    ST_RD_REQ    = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_PUBLISH   = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  // Register map
  localparam logic [5:0] ADDR_POWER_CTL = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FMT  = 6'h31;
  localparam logic [5:0] ADDR_DATA_X0   = 6'h32;  // first of six data bytes

  // Configuration bytes
  localparam logic [7:0] CFG_POWER_CTL  = 8'h08;  // measure mode
  localparam logic [7:0] CFG_DATA_FMT   = 8'h0B;  // full resolution, +/-16 g

  localparam logic [2:0] LAST_DATA_IDX  = 3'd5;
  localparam logic [2:0] LAST_INIT_IDX  = 3'd1;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single-bit level signal.
// Ports:
//   i_clk   destination clock
//   i_rst_n asynchronous active-low reset (both flops clear to 0)
//   i_d     asynchronous input
//   o_q     synchronized output (2 clk latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sensor_poller.sv
// -----------------------------------------------------------------------------
// sensor_poller
// Configures a 3-axis SPI accelerometer once, then reads its six data bytes
// every SAMPLE_PERIOD clocks and publishes x/y/z as one atomic update.
//
// Handshake with the SPI master (valid/ready style): the request fields
// (spi_rw, spi_addr, spi_wdata) are held stable with spi_en high until the
// synchronized busy is seen high; spi_en then drops and the transfer is
// complete when synchronized busy returns low (read data captured that cycle).
// spi_en is never high while synchronized busy is high.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start                        level: run init then poll; 0 = stop after burst
//   o_spi_en/rw/addr/wdata         transaction request to the SPI master
//   i_spi_rdata, i_spi_busy        read byte and busy from the SPI master
//   o_sample_x/y/z, o_sample_valid last complete signed sample and update pulse
//   o_init_done, o_error           init complete level, sticky timeout flag
//   o_state                        current FSM state (debug)
// -----------------------------------------------------------------------------
module sensor_poller
  import sensor_poller_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int TIMEOUT       = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_spi_en,
  output logic        o_spi_rw,
  output logic [5:0]  o_spi_addr,
  output logic [7:0]  o_spi_wdata,
  input  logic [7:0]  i_spi_rdata,
  input  logic        i_spi_busy,
  output logic [15:0] o_sample_x,
  output logic [15:0] o_sample_y,
  output logic [15:0] o_sample_z,
  output logic        o_sample_valid,
  output logic        o_init_done,
  output logic        o_error,
  output state_t      o_state
);

  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PERIOD_LOAD = PW'(SAMPLE_PERIOD - 1);
  // The counter is compared one below TIMEOUT so the fault is entered on the
  // edge where the count would reach TIMEOUT.
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_busy_s;
  logic             w_waiting;
  logic [PW-1:0]    r_period;
  logic [TW-1:0]    r_tmo;
  logic [2:0]       r_idx;
  logic [5:0][7:0]  r_shadow;
  logic [15:0]      r_x;
  logic [15:0]      r_y;
  logic [15:0]      r_z;
  logic             r_valid;
  logic             r_init_done;
  logic             r_error;

  sync_2ff u_busy_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_spi_busy),
    .o_q     (w_busy_s)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_waiting = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = r_init_done ? ST_PERIOD : ST_INIT_REQ;
      end
      ST_INIT_REQ: begin
        w_waiting = !w_busy_s;
        if (w_busy_s) w_next = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        w_waiting = w_busy_s;
        if (!w_busy_s) w_next = (r_idx == LAST_INIT_IDX) ? ST_PERIOD : ST_INIT_REQ;
      end
      ST_PERIOD: begin
        if (r_period == '0) w_next = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        w_waiting = !w_busy_s;
        if (w_busy_s) w_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_waiting = w_busy_s;
        if (!w_busy_s) w_next = (r_idx == LAST_DATA_IDX) ? ST_PUBLISH : ST_RD_REQ;
      end
      ST_PUBLISH: begin
        w_next = i_start ? ST_PERIOD : ST_IDLE;
      end
      ST_FAULT: begin
        w_next = ST_FAULT;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_waiting && (r_tmo == TMO_LAST)) w_next = ST_FAULT;
  end

  // Request fields are pure functions of state and byte index, so they are
  // stable for the whole REQ phase and drop to 0 the instant reset forces IDLE.
  always_comb begin
    o_spi_en    = 1'b0;
    o_spi_rw    = 1'b0;
    o_spi_addr  = 6'h00;
    o_spi_wdata = 8'h00;
    case (r_state)
      ST_INIT_REQ, ST_INIT_WAIT: begin
        o_spi_en    = (r_state == ST_INIT_REQ) && !w_busy_s;
        o_spi_addr  = (r_idx == LAST_INIT_IDX) ? ADDR_DATA_FMT : ADDR_POWER_CTL;
        o_spi_wdata = (r_idx == LAST_INIT_IDX) ? CFG_DATA_FMT  : CFG_POWER_CTL;
      end
      ST_RD_REQ, ST_RD_WAIT: begin
        o_spi_en   = (r_state == ST_RD_REQ) && !w_busy_s;
        o_spi_rw   = 1'b1;
        o_spi_addr = ADDR_DATA_X0 + {3'b000, r_idx};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period    <= '0;
      r_tmo       <= '0;
      r_idx       <= 3'd0;
      r_shadow    <= '0;
      r_x         <= 16'h0000;
      r_y         <= 16'h0000;
      r_z         <= 16'h0000;
      r_valid     <= 1'b0;
      r_init_done <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // Period: loaded at burst start so bursts are SAMPLE_PERIOD apart
      // regardless of how long the reads take.
      if (r_state == ST_PERIOD && w_next == ST_RD_REQ) begin
        r_period <= PERIOD_LOAD;
      end else if ((r_state == ST_PERIOD || r_state == ST_RD_REQ ||
                    r_state == ST_RD_WAIT || r_state == ST_PUBLISH) &&
                   r_period != '0) begin
        r_period <= r_period - PW'(1);
      end

      // Handshake timeout restarts on every state change.
      if (w_next != r_state || !w_waiting) r_tmo <= '0;
      else                                  r_tmo <= r_tmo + TW'(1);

      if (w_next == ST_PERIOD || w_next == ST_IDLE) begin
        r_idx <= 3'd0;
      end else if ((r_state == ST_INIT_WAIT && w_next == ST_INIT_REQ) ||
                   (r_state == ST_RD_WAIT   && w_next == ST_RD_REQ)) begin
        r_idx <= r_idx + 3'd1;
      end

      if (r_state == ST_RD_WAIT && !w_busy_s) r_shadow[r_idx] <= i_spi_rdata;

      // Outputs change only here, so a partial burst is never visible.
      r_valid <= (r_state == ST_PUBLISH);
      if (r_state == ST_PUBLISH) begin
        r_x <= {r_shadow[1], r_shadow[0]};
        r_y <= {r_shadow[3], r_shadow[2]};
        r_z <= {r_shadow[5], r_shadow[4]};
      end

      if (r_state == ST_INIT_WAIT && w_next == ST_PERIOD) r_init_done <= 1'b1;
      if (w_next == ST_FAULT) r_error <= 1'b1;
    end
  end

  assign o_sample_x     = r_x;
  assign o_sample_y     = r_y;
  assign o_sample_z     = r_z;
  assign o_sample_valid = r_valid;
  assign o_init_done    = r_init_done;
  assign o_error        = r_error;
  assign o_state        = r_state;

endmodule

// File: tb/tb_sensor_poller.sv
`timescale 1ns/1ps
module tb_sensor_poller;
  import sensor_poller_pkg::*;

  localparam int SAMPLE_PERIOD = 2000;
  localparam int TIMEOUT       = 1023;
  localparam int W             = 15;  // {rw, addr[5:0], wdata[7:0]}

  // ------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ------------------------------------------------ DUT
  logic        start = 1'b0;
  logic        spi_en, spi_rw;
  logic [5:0]  spi_addr;
  logic [7:0]  spi_wdata, spi_rdata;
  logic        spi_busy;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid, init_done, error;
  state_t      state;

  sensor_poller #(.SAMPLE_PERIOD(SAMPLE_PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .o_spi_en       (spi_en),
    .o_spi_rw       (spi_rw),
    .o_spi_addr     (spi_addr),
    .o_spi_wdata    (spi_wdata),
    .i_spi_rdata    (spi_rdata),
    .i_spi_busy     (spi_busy),
    .o_sample_x     (sample_x),
    .o_sample_y     (sample_y),
    .o_sample_z     (sample_z),
    .o_sample_valid (sample_valid),
    .o_init_done    (init_done),
    .o_error        (error),
    .o_state        (state)
  );

  // ------------------------------------------------ SPI master model
  // Accepts a request when en is seen, raises busy 4 cycles later, holds it
  // 64 cycles, and returns rom[addr-0x32] on the data bus for reads.
  logic [7:0]   rom [6];
  logic         m_active;
  int           m_cnt;
  logic         m_rw;
  logic [5:0]   m_addr;
  logic         m_dead = 1'b0;
  logic [W-1:0] log_q[$];

  function automatic logic [7:0] rom_at(input logic [5:0] a);
    int k;
    k = int'(a) - int'(ADDR_DATA_X0);
    if (k >= 0 && k < 6) return rom[k];
    return 8'h00;
  endfunction

  assign spi_rdata = m_rw ? rom_at(m_addr) : 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_cnt <= 0; spi_busy <= 1'b0; m_rw <= 1'b0; m_addr <= 6'h00;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 4) spi_busy <= 1'b1;
      if (m_cnt == 4 + 64) begin spi_busy <= 1'b0; m_active <= 1'b0; end
    end else if (spi_en && !m_dead) begin
      m_active <= 1'b1; m_cnt <= 1; m_rw <= spi_rw; m_addr <= spi_addr;
      log_q.push_back({spi_rw, spi_addr, spi_wdata});
    end
  end

  // ------------------------------------------------ monitors
  logic b1, b2;  // bench's own view of the synchronized busy
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin b1 <= 1'b0; b2 <= 1'b0; end
    else begin b1 <= spi_busy; b2 <= b1; end
  end

  int    burst_t[$];
  int    init_t = -1;
  int    valid_cnt = 0;
  int    en_busy_viol = 0;
  int    hold_viol = 0;
  logic  en_prev = 1'b0, init_prev = 1'b0;
  logic [47:0] prev_xyz = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_en && !en_prev && spi_rw && spi_addr == ADDR_DATA_X0) burst_t.push_back(cyc);
      if (init_done && !init_prev) init_t = cyc;
      if (sample_valid) valid_cnt++;
      if (spi_en && b2) en_busy_viol++;
      if (!sample_valid && {sample_x, sample_y, sample_z} !== prev_xyz) hold_viol++;
    end
    en_prev   = spi_en;
    init_prev = init_done;
    prev_xyz  = {sample_x, sample_y, sample_z};
  end

  // ------------------------------------------------ scoreboard state
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // ------------------------------------------------ driver tasks
  task automatic set_rom(input logic [47:0] v);
    for (int i = 0; i < 6; i++) rom[i] = v[8*i +: 8];
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    wait_cycles(3);
    n_tests++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
    n_tests++; if ({spi_en, spi_rw, spi_addr, spi_wdata} !== 16'h0) begin n_fail++; $display("FAIL reset_spi: got %h want 0", {spi_en, spi_rw, spi_addr, spi_wdata}); end
    n_tests++; if ({sample_x, sample_y, sample_z, sample_valid, init_done, error} !== 51'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {sample_x, sample_y, sample_z, sample_valid, init_done, error}); end
    rst_n = 1'b1;
    wait_cycles(2);
    n_tests++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d want %0d", state, ST_IDLE); end
  endtask

  task automatic test_init();
    int n;
    logic [W-1:0] got, want;
    exp_q.push_back({1'b0, 6'h2D, 8'h08});
    exp_q.push_back({1'b0, 6'h31, 8'h0B});
    start = 1'b1;
    n = 0;
    while (!init_done && n < 1000) begin @(negedge clk); n++; end
    n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b want 1 within 1000 cycles", init_done); end
    for (int i = 0; i < 2; i++) begin
      want = exp_q.pop_front();
      got  = (log_q.size() > 0) ? log_q.pop_front() : '1;
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL init_write%0d: got %h want %h", i, got, want); end
    end
    n_tests++; if (en_busy_viol != 0) begin n_fail++; $display("FAIL en_while_busy_init: got %0d want 0", en_busy_viol); end
  endtask

  task automatic test_burst();
    int n;
    logic [W-1:0] got, want;
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, 6'(8'h32 + i), 8'h00});
    n = 0;
    while (valid_cnt < 1 && n < 3000) begin @(negedge clk); n++; end
    n_tests++; if (valid_cnt < 1) begin n_fail++; $display("FAIL burst1_valid: got %0d pulses want 1", valid_cnt); end
    n_tests++; if (sample_x !== 16'h0010) begin n_fail++; $display("FAIL burst1_x: got %h want 0010", sample_x); end
    n_tests++; if (sample_y !== 16'hFFF0) begin n_fail++; $display("FAIL burst1_y: got %h want fff0", sample_y); end
    n_tests++; if (sample_z !== 16'h0100) begin n_fail++; $display("FAIL burst1_z: got %h want 0100", sample_z); end
    for (int i = 0; i < 6; i++) begin
      want = exp_q.pop_front();
      got  = (log_q.size() > 0) ? log_q.pop_front() : '1;
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL burst1_read%0d: got %h want %h", i, got, want); end
    end
    n_tests++; if (burst_t.size() < 1 || burst_t[0] != init_t + 1) begin n_fail++; $display("FAIL first_burst_latency: got start %0d want %0d", (burst_t.size() > 0) ? burst_t[0] : -1, init_t + 1); end
    set_rom({8'hAB, 8'hCD, 8'h56, 8'h78, 8'h12, 8'h34});
    wait_cycles(50);
    n_tests++; if (valid_cnt != 1) begin n_fail++; $display("FAIL single_pulse: got %0d pulses want 1", valid_cnt); end
  endtask

  task automatic test_period();
    int n;
    n = 0;
    while (valid_cnt < 3 && n < 5000) begin @(negedge clk); n++; end
    n_tests++; if (valid_cnt != 3) begin n_fail++; $display("FAIL burst3_valid: got %0d pulses want 3", valid_cnt); end
    n_tests++; if ({sample_x, sample_y, sample_z} !== 48'h1234_5678_ABCD) begin n_fail++; $display("FAIL burst3_xyz: got %h want 12345678abcd", {sample_x, sample_y, sample_z}); end
    n_tests++; if (burst_t.size() < 3 || burst_t[1] - burst_t[0] != SAMPLE_PERIOD) begin n_fail++; $display("FAIL period_1_2: got %0d want %0d", (burst_t.size() > 1) ? burst_t[1] - burst_t[0] : -1, SAMPLE_PERIOD); end
    n_tests++; if (burst_t.size() < 3 || burst_t[2] - burst_t[1] != SAMPLE_PERIOD) begin n_fail++; $display("FAIL period_2_3: got %0d want %0d", (burst_t.size() > 2) ? burst_t[2] - burst_t[1] : -1, SAMPLE_PERIOD); end
    n_tests++; if (hold_viol != 0) begin n_fail++; $display("FAIL sample_hold: got %0d changes without valid want 0", hold_viol); end
    n_tests++; if (en_busy_viol != 0) begin n_fail++; $display("FAIL en_while_busy_run: got %0d want 0", en_busy_viol); end
  endtask

  task automatic test_stop_mid_burst();
    int n;
    set_rom({8'hA5, 8'h5A, 8'h80, 8'h00, 8'h7F, 8'hFF});
    n = 0;
    while (!(spi_en && spi_rw && spi_addr == 6'h34) && n < 4000) begin @(negedge clk); n++; end
    n_tests++; if (!(spi_en && spi_addr == 6'h34)) begin n_fail++; $display("FAIL reach_byte2: got addr %h en %b want 34/1", spi_addr, spi_en); end
    start = 1'b0;
    n = 0;
    while (valid_cnt < 4 && n < 1000) begin @(negedge clk); n++; end
    n_tests++; if (valid_cnt != 4) begin n_fail++; $display("FAIL stop_publish: got %0d pulses want 4", valid_cnt); end
    n_tests++; if ({sample_x, sample_y, sample_z} !== 48'h7FFF_8000_A55A) begin n_fail++; $display("FAIL stop_xyz: got %h want 7fff8000a55a", {sample_x, sample_y, sample_z}); end
    wait_cycles(3);
    n_tests++; if (state !== ST_IDLE || spi_en !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got state %0d en %b want %0d/0", state, spi_en, ST_IDLE); end
    wait_cycles(2500);
    n_tests++; if (burst_t.size() != 4) begin n_fail++; $display("FAIL no_burst_after_stop: got %0d bursts want 4", burst_t.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [W-1:0] got;
    start = 1'b1;
    n = 0;
    while (state !== ST_RD_WAIT && n < 4000) begin @(negedge clk); n++; end
    n_tests++; if (state !== ST_RD_WAIT) begin n_fail++; $display("FAIL reach_rd_wait: got %0d want %0d", state, ST_RD_WAIT); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({spi_en, spi_rw, spi_addr, spi_wdata} !== 16'h0) begin n_fail++; $display("FAIL async_reset_spi: got %h want 0", {spi_en, spi_rw, spi_addr, spi_wdata}); end
    n_tests++; if ({sample_x, sample_y, sample_z, sample_valid, init_done, error} !== 51'h0) begin n_fail++; $display("FAIL async_reset_out: got %h want 0", {sample_x, sample_y, sample_z, sample_valid, init_done, error}); end
    n_tests++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL async_reset_state: got %0d want %0d", state, ST_IDLE); end
    wait_cycles(3);
    log_q.delete();
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 1000) begin @(negedge clk); n++; end
    n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL reinit_done: got %b want 1", init_done); end
    got = (log_q.size() > 0) ? log_q.pop_front() : '1;
    n_tests++; if (got !== {1'b0, 6'h2D, 8'h08}) begin n_fail++; $display("FAIL reinit_write0: got %h want %h", got, {1'b0, 6'h2D, 8'h08}); end
  endtask

  task automatic test_timeout();
    int n, t0;
    rst_n = 1'b0;
    m_dead = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    n = 0;
    while (!spi_en && n < 10) begin @(negedge clk); n++; end
    n_tests++; if (spi_en !== 1'b1) begin n_fail++; $display("FAIL tmo_req: got en %b want 1", spi_en); end
    t0 = cyc;
    n = 0;
    while (!error && n < 2000) begin @(negedge clk); n++; end
    n_tests++; if (error !== 1'b1 || cyc - t0 != TIMEOUT) begin n_fail++; $display("FAIL tmo_latency: got error %b after %0d cycles want 1 after %0d", error, cyc - t0, TIMEOUT); end
    n_tests++; if (spi_en !== 1'b0 || state !== ST_FAULT) begin n_fail++; $display("FAIL tmo_fault: got en %b state %0d want 0/%0d", spi_en, state, ST_FAULT); end
    start = 1'b0;
    wait_cycles(50);
    start = 1'b1;
    wait_cycles(50);
    n_tests++; if (state !== ST_FAULT || error !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got state %0d error %b want %0d/1", state, error, ST_FAULT); end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++; if (state !== ST_IDLE || error !== 1'b0) begin n_fail++; $display("FAIL fault_reset: got state %0d error %b want %0d/0", state, error, ST_IDLE); end
    wait_cycles(2);
    rst_n = 1'b1;
    m_dead = 1'b0;
    wait_cycles(2);
  endtask

  // ------------------------------------------------ watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------ sequence and report
  initial begin
    set_rom({8'h01, 8'h00, 8'hFF, 8'hF0, 8'h00, 8'h10});
    test_reset();
    test_init();
    test_burst();
    test_period();
    test_stop_mid_burst();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
